// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one byte-stream requester onto a shared UART transmit port.
// Define UART_ARB_TIMEOUT_EN to revoke a grant after IDLE_TIMEOUT stalled cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           data_in,
    output logic                 data_in_valid,
    input  logic                 data_in_ready,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_BURST < 1 || MAX_BURST > 255 || IDLE_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of legal range");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant_next;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_next;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_next;

    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        sel_last;
    logic        win_found;
    logic [1:0]  win_id;
    logic        xfer;
    logic        release_grant;
    logic        stall_expired;

    always_comb begin
        sel_data  = 8'd0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Scan a doubled index range so the search starting at rr_ptr wraps without modular indexing on signals.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int j = 0; j < 2*NUM_REQ; j++) begin
            if (!win_found && j >= int'(rr_ptr) && j < int'(rr_ptr) + NUM_REQ
                && req_valid[j % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = 2'(j % NUM_REQ);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;

    assign stall_expired = (state == LOCKED) && !sel_valid
                           && (stall_cnt == STALL_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state != LOCKED || sel_valid || stall_expired) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`else
    assign stall_expired = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        grant_next    = grant_id;
        rr_next       = rr_ptr;
        burst_next    = burst_cnt;
        req_ready     = '0;
        data_in       = sel_data;
        data_in_valid = 1'b0;
        xfer          = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = LOCKED;
                    grant_next = win_id;
                    burst_next = 8'd0;
                end
            end
            LOCKED: begin
                data_in_valid = sel_valid;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id == 2'(i)) begin
                        req_ready[i] = data_in_ready;
                    end
                end
                xfer = sel_valid & data_in_ready;
                if (xfer) begin
                    burst_next = burst_cnt + 8'd1;
                    if (sel_last || burst_cnt == 8'(MAX_BURST - 1)) begin
                        release_grant = 1'b1;
                    end
                end
                if (stall_expired) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_next = IDLE;
                    rr_next    = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            grant_id  <= grant_next;
            rr_ptr    <= rr_next;
            burst_cnt <= burst_next;
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a queue-level round-robin model predicts the forwarded byte order.
// The stall test adapts its expectation to UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int NR = 3;
    localparam int MB = 16;
    localparam int IT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      data_in;
    logic            data_in_valid;
    logic            data_in_ready;
    logic [1:0]      grant_id;
    logic            busy;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       rel;
    } exp_t;

    beat_t src_q [NR][$];
    exp_t  exp_q [$];
    int    checks = 0;
    int    errors = 0;
    int    model_rr = 0;
    bit    mon_en = 1'b0;
    bit    rel_pending = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .MAX_BURST(MB),
        .IDLE_TIMEOUT(IT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_data(req_data),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_ready(req_ready),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add_msg(input int r, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = 8'($urandom);
            b.last = (k == len - 1);
            src_q[r].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: serve non-empty queues round-robin, each grant ending on a last byte or MB bytes.
    function automatic void build_expected();
        int    pos [NR];
        int    g;
        int    n;
        bit    rel;
        beat_t b;
        exp_t  e;
        for (int i = 0; i < NR; i++) pos[i] = 0;
        do begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && pos[(model_rr + k) % NR] < src_q[(model_rr + k) % NR].size())
                    g = (model_rr + k) % NR;
            end
            if (g >= 0) begin
                n   = 0;
                rel = 1'b0;
                while (!rel && pos[g] < src_q[g].size()) begin
                    b = src_q[g][pos[g]];
                    pos[g]++;
                    n++;
                    rel    = b.last || (n == MB);
                    e.id   = 2'(g);
                    e.data = b.data;
                    e.rel  = rel;
                    exp_q.push_back(e);
                end
                model_rr = (g + 1) % NR;
            end
        end while (g >= 0);
    endfunction

    task automatic apply_stimulus();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0].data;
                req_last[i]        = src_q[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    // mode 0: random ready, 1: ready toggles each cycle, 2: ready held high
    task automatic run_traffic(input int mode, input int budget, input int stop_accepts);
        int          accepts = 0;
        bit          done = 1'b0;
        logic [NR-1:0] acc;
        for (int c = 0; c < budget && !done; c++) begin
            apply_stimulus();
            case (mode)
                0:       data_in_ready = ($urandom_range(0, 3) != 0);
                1:       data_in_ready = (c % 2 == 0);
                default: data_in_ready = 1'b1;
            endcase
            @(negedge clk);
            acc = req_ready & req_valid;
            next_cycle();
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    src_q[i].delete(0);
                    accepts++;
                end
            end
            if (stop_accepts > 0 && accepts >= stop_accepts) done = 1'b1;
            else if (stop_accepts == 0 && all_empty() && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL traffic_timeout: actual %0d bytes still expected, required 0", exp_q.size());
        end
        apply_stimulus();
    endtask

    task automatic pulse_reset();
        mon_en    = 1'b0;
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        next_cycle();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rel_pending = 1'b0;
        end else if (mon_en) begin
            if (rel_pending) begin
                check("bubble_busy", int'(busy), 0);
                check("bubble_valid", int'(data_in_valid), 0);
                rel_pending = 1'b0;
            end
            if (!busy) begin
                check("idle_valid", int'(data_in_valid), 0);
                check("idle_ready", int'(req_ready), 0);
            end else begin
                check("ready_mirror", int'(req_ready), data_in_ready ? (1 << grant_id) : 0);
            end
            if (data_in_valid && data_in_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_xfer: actual byte %0h from %0d, required none", data_in, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_grant", int'(grant_id), int'(e.id));
                    check("xfer_data", int'(data_in), int'(e.data));
                    rel_pending = e.rel;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stall;
        reset         = 1'b1;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        data_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(data_in_valid), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_grant", int'(grant_id), 0);

        // Two-byte message with cycle-exact timing.
        next_cycle();
        req_valid = 3'b001; req_data[7:0] = 8'h41; req_last = 3'b000; data_in_ready = 1'b1;
        @(negedge clk);
        check("t0_busy", int'(busy), 0);
        check("t0_valid", int'(data_in_valid), 0);
        next_cycle();
        @(negedge clk);
        check("t1_busy", int'(busy), 1);
        check("t1_data", int'(data_in), 'h41);
        check("t1_ready", int'(req_ready), 1);
        next_cycle();
        req_data[7:0] = 8'h42; req_last = 3'b001;
        @(negedge clk);
        check("t2_data", int'(data_in), 'h42);
        check("t2_valid", int'(data_in_valid), 1);
        next_cycle();
        req_valid = '0; req_last = '0;
        @(negedge clk);
        check("t3_busy", int'(busy), 0);
        model_rr = 1;

        // Simultaneous requests with rr_ptr=1, then a 20-byte burst against a pending req0.
        mon_en = 1'b1;
        add_msg(0, 1); add_msg(1, 1);
        build_expected();
        run_traffic(2, 100, 0);
        add_msg(1, 20); add_msg(0, 3);
        build_expected();
        run_traffic(0, 400, 0);

        pulse_reset();
        model_rr = 0;
        mon_en = 1'b1;
        add_msg(0, 1); add_msg(1, 1);
        build_expected();
        run_traffic(2, 100, 0);

        add_msg(2, 4);
        build_expected();
        run_traffic(1, 100, 0);

        for (int round = 0; round < 20; round++) begin
            for (int r = 0; r < NR; r++) begin
                for (int m = $urandom_range(0, 2); m > 0; m--) add_msg(r, $urandom_range(1, 20));
            end
            build_expected();
            run_traffic(0, 2000, 0);
        end

        // Reset in the middle of a five-byte message.
        add_msg(2, 5);
        build_expected();
        run_traffic(2, 100, 2);
        pulse_reset();
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(data_in_valid), 0);
        check("midrst_grant", int'(grant_id), 0);
        check("midrst_ready", int'(req_ready), 0);
        model_rr = 0;
        mon_en = 1'b1;
        add_msg(2, 1); add_msg(1, 1); add_msg(0, 1);
        build_expected();
        run_traffic(0, 200, 0);

        // Granted requester goes silent mid-message.
        pulse_reset();
        req_valid = 3'b011; req_last = 3'b010; data_in_ready = 1'b1;
        req_data[7:0] = 8'h10; req_data[15:8] = 8'h20;
        @(negedge clk);
        check("stl_arb_busy", int'(busy), 0);
        next_cycle();
        @(negedge clk);
        check("stl_grant0", int'(grant_id), 0);
        check("stl_data0", int'(data_in), 'h10);
        next_cycle();
        req_valid[0] = 1'b0;
        stall = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) break;
            stall++;
            check("stl_hold1", int'(req_ready[1]), 0);
            next_cycle();
        end
`ifdef UART_ARB_TIMEOUT_EN
        check("stl_cycles", stall, IT);
        next_cycle();
        @(negedge clk);
        check("stl_grant1", int'(grant_id), 1);
        check("stl_data1", int'(data_in), 'h20);
        next_cycle();
        req_valid = '0;
`else
        check("stl_cycles", stall, 100);
        check("stl_still0", int'(grant_id), 0);
        req_valid[0] = 1'b1; req_last[0] = 1'b1; req_data[7:0] = 8'h11;
        @(negedge clk);
        check("stl_resume", int'(data_in), 'h11);
        check("stl_resume_rdy", int'(req_ready), 1);
        next_cycle();
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        @(negedge clk);
        check("stl_bubble", int'(busy), 0);
        next_cycle();
        @(negedge clk);
        check("stl_grant1", int'(grant_id), 1);
        check("stl_data1", int'(data_in), 'h20);
        next_cycle();
        req_valid = '0;
`endif
        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
